sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning slave cycles allowed per access before abort (legal range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, meaning rdata returned on an aborted access.
REQ-003 SHALL have port i_clk, input, 1, the single clock shared with sys_sdram's controller clock.
REQ-004 SHALL have port i_rstn, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports i_m0_valid, input, 1; o_m0_ready, output, 1; i_m0_addr, input, 32; i_m0_wdata, input, 32; i_m0_wstrb, input, 4; o_m0_rdata, output, 32. These form requester 0.
REQ-006 SHALL have the same six ports with prefix m1 for requester 1.
REQ-007 SHALL have ports o_s_valid, output, 1; i_s_ready, input, 1; o_s_addr, output, 32; o_s_wdata, output, 32; o_s_wstrb, output, 4; i_s_rdata, input, 32. These connect to sys_sdram.
REQ-008 SHALL have port o_timeout, output, 1: one-cycle pulse when an access is aborted.

Function
REQ-009 Protocol on all ports SHALL be valid/ready: a requester holds valid and its fields stable until it sees a one-cycle ready pulse; wstrb of 0 means read, otherwise byte-enabled write.
REQ-010 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-011 IDLE SHALL transition to BUSY on any requester valid, latching the grant index and that requester's addr/wdata/wstrb into the slave output registers.
REQ-012 A grant SHALL be issued when only one requester is valid; when both are valid, the requester not served last wins (round-robin last-served pointer).
REQ-013 o_s_valid SHALL be 1 exactly in BUSY; slave fields SHALL be stable throughout BUSY. Latency: requester valid sampled at edge N gives o_s_valid=1 after edge N.
REQ-014 In BUSY, i_s_ready=1 SHALL capture i_s_rdata into the granted requester's rdata register, update the last-served pointer, and transition to DONE.
REQ-015 In DONE, the granted o_mX_ready SHALL be 1 for exactly one cycle, o_s_valid SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-016 This gives a minimum of 3 cycles per access (IDLE, BUSY, DONE) and guarantees the served requester has dropped valid before re-arbitration.
REQ-017 A 16-bit BUSY cycle counter SHALL clear on entry to BUSY; if it reaches TIMEOUT_CYCLES-1 with i_s_ready=0, the FSM SHALL go to DONE and load ERR_RDATA as rdata.
REQ-018 On that abort, o_timeout SHALL pulse concurrently with the ready pulse and the last-served pointer SHALL update.
REQ-019 If i_s_ready=1 in the timeout cycle, it SHALL count as normal completion: real rdata is returned and there is no o_timeout.
REQ-020 i_s_ready outside BUSY SHALL be ignored.
REQ-021 The non-granted requester SHALL see ready=0, and its rdata SHALL hold its last value.
REQ-022 A requester dropping valid mid-BUSY is a protocol violation; the access SHALL complete anyway.

Reset
REQ-023 Reset SHALL put the FSM in IDLE.
REQ-024 Reset SHALL set o_s_valid=0, o_s_addr/wdata=0, o_s_wstrb=0, o_m0_ready=o_m1_ready=0, o_m0_rdata=o_m1_rdata=0, o_timeout=0 and the counter to 0.
REQ-025 Reset SHALL set the last-served pointer to 1, so m0 wins the first contention.
REQ-026 Reset asserted mid-BUSY SHALL drop o_s_valid immediately (asynchronously), and no ready pulse SHALL follow deassertion.

Structure
REQ-027 Package sdram_arb_pkg SHALL hold the FSM state enum (IDLE/BUSY/DONE), the counter width 16, and the default ERR_RDATA constant.
REQ-028 The design SHALL be a single module with no sub-module; the arbitration is a 2-way round-robin inline.
REQ-029 The top level SHALL instantiate the block between the tester, a second requester and sys_sdram, all on the sdram_ctrl_clk domain.

Verification
REQ-030 Single read: m0 valid, addr=0x10, wstrb=0; slave ready after 5 BUSY cycles with rdata=0x12345678 -> o_m0_rdata=0x12345678, one o_m0_ready pulse, o_m1_ready stays 0.
REQ-031 Contention: both valid in the same cycle after reset -> m0 served first, then m1, with o_s_addr switching only in IDLE.
REQ-032 Sustained contention with both held valid for 6 accesses -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-033 Timeout: TIMEOUT_CYCLES=8, slave never ready -> exactly 8 BUSY cycles, then o_m1_ready and o_timeout pulse together with rdata=0xDEADBEEF.
REQ-034 Boundary: i_s_ready on the 8th BUSY cycle -> real rdata is returned and o_timeout=0.
REQ-035 Reset mid-BUSY of a write wstrb=4'hF -> o_s_valid=0 during reset, all outputs at reset values, and a fresh access completes normally afterwards.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM arbiter.
// No logic; imported by sdram_arbiter.
// Not applicable (package only).
package sdram_arb_pkg;

    // Arbiter FSM: wait for a request, hold it on the slave, acknowledge the requester.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Width of the per-access BUSY cycle counter used for the abort timer.
    localparam int CNT_W = 16;

    // Read data handed back when an access is abandoned by the timer.
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/sdram_arbiter.sv
// Two-way round-robin arbiter in front of sys_sdram, with per-access abort timer.
// Latency: request sampled in IDLE -> o_s_valid next cycle; requester ready one cycle after slave ready.
// Backpressure: one access in flight; requesters wait on valid until their one-cycle ready pulse.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rstn,

    input  logic        i_m0_valid,
    output logic        o_m0_ready,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_wstrb,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_valid,
    output logic        o_m1_ready,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_wstrb,
    output logic [31:0] o_m1_rdata,

    output logic        o_s_valid,
    input  logic        i_s_ready,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_wstrb,
    input  logic [31:0] i_s_rdata,

    output logic        o_timeout
);

    // Counter value on the last BUSY cycle allowed before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;     // index of the requester being served
    logic              last_q,  last_d;      // index of the requester served most recently
    logic              abort_q, abort_d;     // current DONE was reached by the timer
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [31:0]       s_addr_q,  s_addr_d;
    logic [31:0]       s_wdata_q, s_wdata_d;
    logic [3:0]        s_wstrb_q, s_wstrb_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;
    logic              pick;

    // Round-robin choice: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        pick = 1'b0;
        if (i_m0_valid && i_m1_valid) begin
            pick = ~last_q;
        end else if (i_m1_valid) begin
            pick = 1'b1;
        end
    end

    // Next-state logic: grant in IDLE, wait for slave or timer in BUSY, acknowledge in DONE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        abort_d    = abort_q;
        cnt_d      = cnt_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (i_m0_valid || i_m1_valid) begin
                    state_d   = BUSY;
                    grant_d   = pick;
                    abort_d   = 1'b0;
                    cnt_d     = '0;
                    s_addr_d  = pick ? i_m1_addr  : i_m0_addr;
                    s_wdata_d = pick ? i_m1_wdata : i_m0_wdata;
                    s_wstrb_d = pick ? i_m1_wstrb : i_m0_wstrb;
                end
            end
            BUSY: begin
                // Slave completion wins over the timer when both land on the same cycle.
                if (i_s_ready) begin
                    state_d = DONE;
                    last_d  = grant_q;
                    abort_d = 1'b0;
                    if (grant_q) m1_rdata_d = i_s_rdata;
                    else         m0_rdata_d = i_s_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    last_d  = grant_q;
                    abort_d = 1'b1;
                    if (grant_q) m1_rdata_d = ERR_RDATA;
                    else         m0_rdata_d = ERR_RDATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; last-served starts at 1 so m0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            abort_q    <= 1'b0;
            cnt_q      <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Handshake outputs decode straight from the state register, so reset clears them at once.
    always_comb begin
        o_s_valid  = (state_q == BUSY);
        o_m0_ready = (state_q == DONE) && !grant_q;
        o_m1_ready = (state_q == DONE) &&  grant_q;
        o_timeout  = (state_q == DONE) &&  abort_q;
        o_s_addr   = s_addr_q;
        o_s_wdata  = s_wdata_q;
        o_s_wstrb  = s_wstrb_q;
        o_m0_rdata = m0_rdata_q;
        o_m1_rdata = m1_rdata_q;
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with an 8-cycle abort timer.
// Inputs change and outputs are sampled on the falling clock edge.
// The slave side is driven by the serve task, which asserts i_s_ready after a chosen BUSY count.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic        i_m0_valid, i_m1_valid;
    logic        o_m0_ready, o_m1_ready;
    logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
    logic [3:0]  i_m0_wstrb, i_m1_wstrb;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_s_valid, i_s_ready;
    logic [31:0] o_s_addr, o_s_wdata, i_s_rdata;
    logic [3:0]  o_s_wstrb;
    logic        o_timeout;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (i_rstn),
        .i_m0_valid(i_m0_valid),
        .o_m0_ready(o_m0_ready),
        .i_m0_addr (i_m0_addr),
        .i_m0_wdata(i_m0_wdata),
        .i_m0_wstrb(i_m0_wstrb),
        .o_m0_rdata(o_m0_rdata),
        .i_m1_valid(i_m1_valid),
        .o_m1_ready(o_m1_ready),
        .i_m1_addr (i_m1_addr),
        .i_m1_wdata(i_m1_wdata),
        .i_m1_wstrb(i_m1_wstrb),
        .o_m1_rdata(o_m1_rdata),
        .o_s_valid (o_s_valid),
        .i_s_ready (i_s_ready),
        .o_s_addr  (o_s_addr),
        .o_s_wdata (o_s_wdata),
        .o_s_wstrb (o_s_wstrb),
        .i_s_rdata (i_s_rdata),
        .o_timeout (o_timeout)
    );

    task automatic clear_inputs();
        i_m0_valid = 0; i_m0_addr = 0; i_m0_wdata = 0; i_m0_wstrb = 0;
        i_m1_valid = 0; i_m1_addr = 0; i_m1_wdata = 0; i_m1_wstrb = 0;
        i_s_ready  = 0; i_s_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rstn = 0;
        repeat (2) @(negedge clk);
        i_rstn = 1;
    endtask

    // Play the slave for one access: ready goes high on BUSY cycle rdy_at (0 = never).
    // Returns at the falling edge where a requester ready is seen; busy = -1 if none within the bound.
    task automatic serve(input int rdy_at, input logic [31:0] rd,
                         output int busy, output logic [1:0] rdys, output logic to_seen,
                         output logic sv_done, output logic [31:0] addr, output logic stable);
        bit seen;
        busy = 0; rdys = 2'b00; to_seen = 0; sv_done = 0; addr = '0; stable = 1; seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (o_m0_ready || o_m1_ready) begin
                rdys      = {o_m1_ready, o_m0_ready};
                to_seen   = o_timeout;
                sv_done   = o_s_valid;
                seen      = 1;
                i_s_ready = 0;
            end else if (o_s_valid) begin
                if (busy == 0) addr = o_s_addr;
                else if (o_s_addr !== addr) stable = 0;
                busy++;
                if (busy == rdy_at) begin
                    i_s_ready = 1;
                    i_s_rdata = rd;
                end
            end
        end
        if (!seen) busy = -1;
    endtask

    task automatic test_reset();
        i_rstn = 0;
        clear_inputs();
        #12;
        checks++; if (o_s_valid !== 1'b0) $display("FAIL reset_s_valid got=%0b exp=0", o_s_valid); else passes++;
        checks++; if ({o_m1_ready, o_m0_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {o_m1_ready, o_m0_ready}); else passes++;
        checks++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout got=%0b exp=0", o_timeout); else passes++;
        checks++; if ({o_s_addr, o_s_wdata, o_s_wstrb} !== 68'h0) $display("FAIL reset_s_fields got=%h exp=0", {o_s_addr, o_s_wdata, o_s_wstrb}); else passes++;
        checks++; if ({o_m0_rdata, o_m1_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", {o_m0_rdata, o_m1_rdata}); else passes++;
        @(negedge clk);
        i_rstn = 1;
    endtask

    task automatic test_single_read();
        int busy; logic [1:0] rdys; logic to_seen, sv, stable; logic [31:0] addr;
        do_reset();
        i_m0_valid = 1; i_m0_addr = 32'h10; i_m0_wstrb = 4'h0;
        serve(5, 32'h1234_5678, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (busy !== 5) $display("FAIL single_busy_cycles got=%0d exp=5", busy); else passes++;
        checks++; if (rdys !== 2'b01) $display("FAIL single_ready got=%b exp=01", rdys); else passes++;
        checks++; if (o_m0_rdata !== 32'h1234_5678) $display("FAIL single_rdata got=%h exp=12345678", o_m0_rdata); else passes++;
        checks++; if (addr !== 32'h10 || o_s_wstrb !== 4'h0) $display("FAIL single_s_fields got=%h/%h exp=10/0", addr, o_s_wstrb); else passes++;
        checks++; if (sv !== 1'b0 || to_seen !== 1'b0) $display("FAIL single_done_flags got=%b%b exp=00", sv, to_seen); else passes++;
        i_m0_valid = 0;
        @(negedge clk);
        checks++; if ({o_m1_ready, o_m0_ready} !== 2'b00) $display("FAIL single_one_pulse got=%b exp=00", {o_m1_ready, o_m0_ready}); else passes++;
        checks++; if (o_m1_rdata !== 32'h0) $display("FAIL single_m1_rdata_hold got=%h exp=0", o_m1_rdata); else passes++;
    endtask

    task automatic test_contention();
        int busy; logic [1:0] rdys; logic to_seen, sv, stable; logic [31:0] addr;
        do_reset();
        i_m0_valid = 1; i_m0_addr = 32'h100; i_m0_wdata = 32'hAAAA_0000; i_m0_wstrb = 4'h3;
        i_m1_valid = 1; i_m1_addr = 32'h200; i_m1_wdata = 32'hBBBB_0000; i_m1_wstrb = 4'hC;
        serve(1, 32'h1111_1111, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (rdys !== 2'b01 || addr !== 32'h100) $display("FAIL cont_first got=%b/%h exp=01/100", rdys, addr); else passes++;
        checks++; if (o_s_wdata !== 32'hAAAA_0000 || o_s_wstrb !== 4'h3) $display("FAIL cont_first_wr got=%h/%h exp=aaaa0000/3", o_s_wdata, o_s_wstrb); else passes++;
        i_m0_valid = 0;
        @(negedge clk);
        checks++; if (o_s_valid !== 1'b0 || o_s_addr !== 32'h100) $display("FAIL cont_idle got=%b/%h exp=0/100", o_s_valid, o_s_addr); else passes++;
        serve(1, 32'h2222_2222, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (rdys !== 2'b10 || addr !== 32'h200 || !stable) $display("FAIL cont_second got=%b/%h/%b exp=10/200/1", rdys, addr, stable); else passes++;
        checks++; if (o_m1_rdata !== 32'h2222_2222 || o_m0_rdata !== 32'h1111_1111) $display("FAIL cont_rdata got=%h/%h exp=11111111/22222222", o_m0_rdata, o_m1_rdata); else passes++;
        i_m1_valid = 0;
    endtask

    task automatic test_back_to_back();
        int busy; logic [1:0] rdys; logic to_seen, sv, stable; logic [31:0] addr;
        logic [31:0] a0, a1, e0, e1, exp_addr;
        logic [1:0] exp_rdys;
        do_reset();
        a0 = 32'h1000; a1 = 32'h2000; e0 = 0; e1 = 0;
        i_m0_valid = 1; i_m0_addr = a0;
        i_m1_valid = 1; i_m1_addr = a1;
        for (int i = 0; i < 6; i++) begin
            exp_rdys = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 1) ? a1 : a0;
            serve(2 + (i % 3), 32'hA000_0000 + i, busy, rdys, to_seen, sv, addr, stable);
            if (i % 2 == 1) e1 = 32'hA000_0000 + i; else e0 = 32'hA000_0000 + i;
            checks++; if (rdys !== exp_rdys || addr !== exp_addr || !stable) $display("FAIL rr_grant_%0d got=%b/%h exp=%b/%h", i, rdys, addr, exp_rdys, exp_addr); else passes++;
            checks++; if (o_m0_rdata !== e0 || o_m1_rdata !== e1) $display("FAIL rr_rdata_%0d got=%h/%h exp=%h/%h", i, o_m0_rdata, o_m1_rdata, e0, e1); else passes++;
            // The served requester immediately presents its next request.
            if (i % 2 == 1) begin a1 = a1 + 4; i_m1_addr = a1; end
            else            begin a0 = a0 + 4; i_m0_addr = a0; end
        end
        i_m0_valid = 0; i_m1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy; logic [1:0] rdys; logic to_seen, sv, stable; logic [31:0] addr;
        do_reset();
        i_m1_valid = 1; i_m1_addr = 32'h300; i_m1_wdata = 32'h0F0F_0F0F; i_m1_wstrb = 4'hF;
        serve(0, 32'h0, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (busy !== 8) $display("FAIL to_busy_cycles got=%0d exp=8", busy); else passes++;
        checks++; if (rdys !== 2'b10 || to_seen !== 1'b1) $display("FAIL to_pulse got=%b/%b exp=10/1", rdys, to_seen); else passes++;
        checks++; if (o_m1_rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata got=%h exp=deadbeef", o_m1_rdata); else passes++;
        checks++; if (o_s_wdata !== 32'h0F0F_0F0F || o_s_wstrb !== 4'hF) $display("FAIL to_s_fields got=%h/%h exp=0f0f0f0f/f", o_s_wdata, o_s_wstrb); else passes++;
        i_m1_valid = 0;
        @(negedge clk);
        checks++; if (o_timeout !== 1'b0 || o_m1_ready !== 1'b0) $display("FAIL to_one_pulse got=%b/%b exp=0/0", o_timeout, o_m1_ready); else passes++;
        // Boundary: slave ready on the final allowed BUSY cycle completes normally.
        i_m0_valid = 1; i_m0_addr = 32'h400; i_m0_wstrb = 4'h0;
        serve(8, 32'hCAFE_F00D, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (busy !== 8 || rdys !== 2'b01) $display("FAIL edge_busy got=%0d/%b exp=8/01", busy, rdys); else passes++;
        checks++; if (to_seen !== 1'b0 || o_m0_rdata !== 32'hCAFE_F00D) $display("FAIL edge_rdata got=%b/%h exp=0/cafef00d", to_seen, o_m0_rdata); else passes++;
        i_m0_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int busy; int spurious; logic [1:0] rdys; logic to_seen, sv, stable; logic [31:0] addr;
        do_reset();
        i_m0_valid = 1; i_m0_addr = 32'h40; i_m0_wdata = 32'h55AA_55AA; i_m0_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        checks++; if (o_s_valid !== 1'b1 || o_s_wstrb !== 4'hF) $display("FAIL rst_pre_busy got=%b/%h exp=1/f", o_s_valid, o_s_wstrb); else passes++;
        @(posedge clk);
        #3 i_rstn = 0;
        #1;
        checks++; if (o_s_valid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", o_s_valid); else passes++;
        checks++; if ({o_s_addr, o_s_wdata, o_s_wstrb} !== 68'h0 || {o_m0_ready, o_m1_ready, o_timeout} !== 3'b000) $display("FAIL rst_outputs got=%h/%b exp=0/000", {o_s_addr, o_s_wdata, o_s_wstrb}, {o_m0_ready, o_m1_ready, o_timeout}); else passes++;
        i_m0_valid = 0;
        @(negedge clk);
        i_rstn = 1;
        i_s_ready = 1;   // must be ignored while idle
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_m0_ready || o_m1_ready || o_s_valid) spurious++;
        end
        i_s_ready = 0;
        checks++; if (spurious !== 0) $display("FAIL rst_no_pulse got=%0d exp=0", spurious); else passes++;
        i_m1_valid = 1; i_m1_addr = 32'h80; i_m1_wstrb = 4'h0;
        serve(2, 32'h0BAD_CAFE, busy, rdys, to_seen, sv, addr, stable);
        checks++; if (rdys !== 2'b10 || addr !== 32'h80 || o_m1_rdata !== 32'h0BAD_CAFE) $display("FAIL rst_fresh got=%b/%h/%h exp=10/80/0badcafe", rdys, addr, o_m1_rdata); else passes++;
        checks++; if (o_m0_rdata !== 32'h0) $display("FAIL rst_m0_rdata got=%h exp=0", o_m0_rdata); else passes++;
        i_m1_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
